// File: rtl/fetch_pkg.sv
// Shared defaults and types for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned DEF_ADDR_W  = 16;
  localparam int unsigned DEF_INSTR_W = 16;
  localparam int unsigned DEF_DEPTH   = 4;

  // One prefetched instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0]  pc;
    logic [DEF_INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Occupancy counters must represent 0..depth inclusive.
  function automatic int unsigned count_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding prefetched {pc, instr} entries.
// Clear outranks push; a pop on an empty queue is ignored.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_ADDR_W + DEF_INSTR_W,
  parameter int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = count_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  // Pointer and occupancy next-state; clear wins over push and pop.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != '0);
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)   wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; count gates validity, so stale contents are never observed.
    if (push && !clear) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one read per cycle to a
// 1-cycle synchronous instruction memory, buffers {pc, instr} in a prefetch
// queue and presents the head to decode over valid/ready. A redirect reloads
// the PC and squashes everything queued or in flight.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DEF_ADDR_W,
  parameter int unsigned       INSTR_W  = DEF_INSTR_W,
  parameter int unsigned       DEPTH    = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [INSTR_W-1:0]         imem_data,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [INSTR_W-1:0]         dec_instr,
  output logic [ADDR_W-1:0]          dec_pc,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int unsigned CNT_W = count_w(DEPTH);
  localparam int unsigned ENT_W = ADDR_W + INSTR_W;
  localparam logic [CNT_W:0] DEPTH_OCC = DEPTH[CNT_W:0];

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;
  logic              issue;
  logic              push;
  logic              pop;
  logic              clear;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occupancy;
  logic [ENT_W-1:0]  push_data;
  logic [ENT_W-1:0]  head_data;

  // Issue only when the queue can absorb every outstanding fetch; the
  // same-cycle pop is ignored on purpose so overflow cannot happen.
  always_comb begin
    occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
    issue     = !reset && !redirect && (occupancy < DEPTH_OCC);
  end

  // PC and in-flight tracking next-state; redirect takes precedence.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      pc_d          = pc_q + ADDR_W'(1);
      inflight_pc_d = pc_q;
    end
  end

  // PC and in-flight registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  // A returning response is dropped when a redirect squashes it.
  assign push      = inflight_q && !redirect;
  assign clear     = reset || redirect;
  assign pop       = dec_valid && dec_ready;
  assign push_data = {inflight_pc_q, imem_data};

  fetch_queue #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (count)
  );

  assign imem_req  = issue;
  assign imem_addr = pc_q;
  assign dec_valid = (count != '0);
  assign dec_pc    = head_data[ENT_W-1:INSTR_W];
  assign dec_instr = head_data[INSTR_W-1:0];
  assign q_count   = count;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a scoreboard of expected {pc, instr}
// entries is filled as stimulus is driven and drained on each handshake.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        dec_ready;
  logic [15:0] rom_key;

  logic        imem_req, dec_valid;
  logic [15:0] imem_addr, imem_data, dec_instr, dec_pc;
  logic [2:0]  q_count;

  logic        w_imem_req, w_dec_valid;
  logic [15:0] w_imem_addr, w_imem_data, w_dec_instr, w_dec_pc;
  logic [2:0]  w_q_count;

  int checks = 0;
  int errors = 0;
  fetch_entry_t exp_q[$];
  fetch_entry_t exp_e;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(16), .INSTR_W(16), .DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_data(imem_data), .redirect(redirect), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
    .dec_pc(dec_pc), .q_count(q_count)
  );

  fetch_unit #(.ADDR_W(16), .INSTR_W(16), .DEPTH(4), .RESET_PC(16'hFFFE)) dut_w (
    .clk(clk), .reset(reset), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_data(w_imem_data), .redirect(redirect), .redirect_pc(redirect_pc),
    .dec_valid(w_dec_valid), .dec_ready(dec_ready), .dec_instr(w_dec_instr),
    .dec_pc(w_dec_pc), .q_count(w_q_count)
  );

  // Synchronous-read ROMs, 1-cycle latency; word = address ^ rom_key.
  always @(posedge clk) if (imem_req)   imem_data   <= imem_addr ^ rom_key;
  always @(posedge clk) if (w_imem_req) w_imem_data <= w_imem_addr ^ rom_key;

  task automatic do_reset(input logic [15:0] key);
    @(negedge clk);
    reset = 1'b1; redirect = 1'b0; dec_ready = 1'b0; rom_key = key;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    #1;
  endtask

  task automatic push_exp(input logic [15:0] start, input int n, input logic [15:0] key);
    fetch_entry_t e;
    logic [15:0] p;
    p = start;
    for (int i = 0; i < n; i++) begin
      e.pc = p; e.instr = p ^ key;
      exp_q.push_back(e);
      p = p + 16'd1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; redirect = 1'b0; redirect_pc = 16'h0; dec_ready = 1'b0; rom_key = 16'h0;
    repeat (3) @(negedge clk);
    checks += 3;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req); end
    if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", dec_valid); end
    if (q_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", q_count); end
    reset = 1'b0; #1;
    checks += 2;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b want 1", imem_req); end
    if (imem_addr !== 16'h0000) begin errors++; $display("FAIL first_addr got %h want 0000", imem_addr); end
    @(negedge clk);
    checks++;
    if (dec_valid !== 1'b0) begin errors++; $display("FAIL lat_early got %b want 0", dec_valid); end
    @(negedge clk);
    checks += 2;
    if (dec_valid !== 1'b1) begin errors++; $display("FAIL lat_valid got %b want 1", dec_valid); end
    if (dec_pc !== 16'h0000) begin errors++; $display("FAIL lat_pc got %h want 0000", dec_pc); end
  endtask

  task automatic test_stream();
    int n;
    bit started;
    do_reset(16'h0000);
    dec_ready = 1'b1;
    push_exp(16'h0000, 12, 16'h0000);
    n = 0; started = 0;
    while (exp_q.size() != 0 && n < 60) begin
      if (started) begin
        checks++;
        if (dec_valid !== 1'b1) begin errors++; $display("FAIL stream_gap got valid=%b want 1", dec_valid); end
      end
      if (dec_valid === 1'b1) begin
        exp_e = exp_q.pop_front(); checks++; started = 1;
        if (dec_pc !== exp_e.pc || dec_instr !== exp_e.instr) begin
          errors++;
          $display("FAIL stream_data got pc=%h instr=%h want pc=%h instr=%h", dec_pc, dec_instr, exp_e.pc, exp_e.instr);
        end
      end
      @(negedge clk); n++;
    end
    if (exp_q.size() != 0) begin checks++; errors++; $display("FAIL stream_timeout got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_stall();
    int n;
    do_reset(16'hC3A5);
    push_exp(16'h0000, 12, 16'hC3A5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req cycle %0d got %b want 0", i, imem_req); end
      end
    end
    checks++;
    if (q_count !== 3'd4) begin errors++; $display("FAIL stall_count got %0d want 4", q_count); end
    dec_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      if (n == 0) begin
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL resume_early got %b want 0", imem_req); end
      end
      if (n == 1) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0004) begin
          errors++; $display("FAIL resume_req got req=%b addr=%h want req=1 addr=0004", imem_req, imem_addr);
        end
      end
      checks++;
      if (dec_valid !== 1'b1) begin
        errors++; $display("FAIL stall_gap got valid=%b want 1", dec_valid);
      end else begin
        exp_e = exp_q.pop_front(); checks++;
        if (dec_pc !== exp_e.pc || dec_instr !== exp_e.instr) begin
          errors++;
          $display("FAIL stall_data got pc=%h instr=%h want pc=%h instr=%h", dec_pc, dec_instr, exp_e.pc, exp_e.instr);
        end
      end
      @(negedge clk); n++;
    end
    if (exp_q.size() != 0) begin checks++; errors++; $display("FAIL stall_timeout got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_redirect();
    int n;
    do_reset(16'h5A5A);
    repeat (4) @(negedge clk);
    checks += 2;
    if (q_count !== 3'd3) begin errors++; $display("FAIL redir_pre_count got %0d want 3", q_count); end
    if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_pre_req got %b want 0", imem_req); end
    redirect = 1'b1; redirect_pc = 16'h0100;
    @(negedge clk);
    redirect = 1'b0; #1;
    checks += 3;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin
      errors++; $display("FAIL redir_req got req=%b addr=%h want req=1 addr=0100", imem_req, imem_addr);
    end
    if (dec_valid !== 1'b0) begin errors++; $display("FAIL redir_valid1 got %b want 0", dec_valid); end
    if (q_count !== 3'd0) begin errors++; $display("FAIL redir_count got %0d want 0", q_count); end
    @(negedge clk);
    checks++;
    if (dec_valid !== 1'b0) begin errors++; $display("FAIL redir_valid2 got %b want 0", dec_valid); end
    @(negedge clk);
    checks += 2;
    if (dec_valid !== 1'b1) begin errors++; $display("FAIL redir_valid3 got %b want 1", dec_valid); end
    if (dec_pc !== 16'h0100) begin errors++; $display("FAIL redir_pc got %h want 0100", dec_pc); end
    push_exp(16'h0100, 6, 16'h5A5A);
    dec_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      if (dec_valid === 1'b1) begin
        exp_e = exp_q.pop_front(); checks++;
        if (dec_pc !== exp_e.pc || dec_instr !== exp_e.instr) begin
          errors++;
          $display("FAIL redir_data got pc=%h instr=%h want pc=%h instr=%h", dec_pc, dec_instr, exp_e.pc, exp_e.instr);
        end
      end
      @(negedge clk); n++;
    end
    if (exp_q.size() != 0) begin checks++; errors++; $display("FAIL redir_timeout got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_redirect_handshake();
    int n;
    bit redirected;
    do_reset(16'h0F0F);
    dec_ready = 1'b1;
    push_exp(16'h0000, 3, 16'h0F0F);
    n = 0; redirected = 0;
    while (exp_q.size() != 0 && n < 60) begin
      redirect = 1'b0;
      if (dec_valid === 1'b1) begin
        exp_e = exp_q.pop_front(); checks++;
        if (dec_pc !== exp_e.pc || dec_instr !== exp_e.instr) begin
          errors++;
          $display("FAIL rh_data got pc=%h instr=%h want pc=%h instr=%h", dec_pc, dec_instr, exp_e.pc, exp_e.instr);
        end
        if (exp_e.pc == 16'h0002 && !redirected) begin
          redirect = 1'b1; redirect_pc = 16'h0200; redirected = 1;
          push_exp(16'h0200, 4, 16'h0F0F);
        end
      end
      @(negedge clk); n++;
    end
    redirect = 1'b0;
    if (exp_q.size() != 0) begin checks++; errors++; $display("FAIL rh_timeout got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    int n;
    do_reset(16'h3C3C);
    checks++;
    if (w_imem_req !== 1'b1 || w_imem_addr !== 16'hFFFE) begin
      errors++; $display("FAIL wrap_first got req=%b addr=%h want req=1 addr=fffe", w_imem_req, w_imem_addr);
    end
    dec_ready = 1'b1;
    push_exp(16'hFFFE, 4, 16'h3C3C);
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      if (w_dec_valid === 1'b1) begin
        exp_e = exp_q.pop_front(); checks++;
        if (w_dec_pc !== exp_e.pc || w_dec_instr !== exp_e.instr) begin
          errors++;
          $display("FAIL wrap_data got pc=%h instr=%h want pc=%h instr=%h", w_dec_pc, w_dec_instr, exp_e.pc, exp_e.instr);
        end
      end
      @(negedge clk); n++;
    end
    if (exp_q.size() != 0) begin checks++; errors++; $display("FAIL wrap_timeout got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset(16'h9999);
    repeat (8) @(negedge clk);
    checks++;
    if (q_count !== 3'd4) begin errors++; $display("FAIL mid_full got %0d want 4", q_count); end
    reset = 1'b1;
    @(negedge clk);
    checks += 3;
    if (dec_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", dec_valid); end
    if (q_count !== 3'd0) begin errors++; $display("FAIL mid_count got %0d want 0", q_count); end
    if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_req got %b want 0", imem_req); end
    reset = 1'b0; #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      errors++; $display("FAIL mid_restart got req=%b addr=%h want req=1 addr=0000", imem_req, imem_addr);
    end
    push_exp(16'h0000, 4, 16'h9999);
    dec_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      if (dec_valid === 1'b1) begin
        exp_e = exp_q.pop_front(); checks++;
        if (dec_pc !== exp_e.pc || dec_instr !== exp_e.instr) begin
          errors++;
          $display("FAIL mid_data got pc=%h instr=%h want pc=%h instr=%h", dec_pc, dec_instr, exp_e.pc, exp_e.instr);
        end
      end
      @(negedge clk); n++;
    end
    if (exp_q.size() != 0) begin checks++; errors++; $display("FAIL mid_timeout got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = 16'h0; dec_ready = 1'b0; rom_key = 16'h0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_handshake();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
